rc5_sequencer: RTL and testbench

Top-level controller for the RC5 core. It runs key expansion after reset or on rekey, then serves one encrypt or decrypt request at a time over a valid/ready handshake. It owns the start lines of `cipher` and `decipher` and the select for the shared S_RAM address ports. It replaces the fixed expander→cipher→decipher flop chain with a request-driven FSM.

---
 rtl/rc5_sequencer.sv | 164 ++++++++++++++++
 tb/tb_rc5_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_sequencer.sv
// Request-driven controller for the RC5 core: runs key expansion, then serves
// one encrypt/decrypt request at a time and owns the engine starts and S_RAM select.
module rc5_sequencer #(
  parameter int W = 16,
  parameter int R = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iReqValid,
  input  logic         iReqDecrypt,
  input  logic [W-1:0] iA,
  input  logic [W-1:0] iB,
  output logic         oReqReady,
  input  logic         iRekey,
  output logic         oExpanderRst,
  input  logic         iExpanderDone,
  output logic         oCipherStart,
  input  logic         iCipherDone,
  input  logic [W-1:0] iCipherA,
  input  logic [W-1:0] iCipherB,
  output logic         oDecipherStart,
  input  logic         iDecipherDone,
  input  logic [W-1:0] iDecipherA,
  input  logic [W-1:0] iDecipherB,
  output logic [W-1:0] oEngA,
  output logic [W-1:0] oEngB,
  output logic [1:0]   oSSel,
  output logic [W-1:0] oA,
  output logic [W-1:0] oB,
  output logic         oRespValid,
  output logic         oRespDecrypt,
  input  logic         iRespReady,
  output logic         oBusy,
  output logic [2:0]   dbg_state
);

  // Handshakes: a request transfers on a rising edge where iReqValid & oReqReady;
  // a response transfers where oRespValid & iRespReady. Both sides hold until then.

  if (R < 1) begin : g_bad_r
    $error("rc5_sequencer: R must be positive");
  end

  typedef enum logic [2:0] {
    KEY_RST  = 3'd0,
    KEY_WAIT = 3'd1,
    IDLE     = 3'd2,
    SETTLE   = 3'd3,
    RUN      = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam logic [1:0] SEL_EXP = 2'd0;
  localparam logic [1:0] SEL_CIP = 2'd1;
  localparam logic [1:0] SEL_DEC = 2'd2;

  state_t         state, state_n;
  logic           rekey_pending, rekey_pending_n;
  logic           mode, mode_n;
  logic [W-1:0]   eng_a_n, eng_b_n, a_n, b_n;
  logic [1:0]     ssel_n;
  logic           cstart_n, dstart_n, resp_valid_n, resp_dec_n;
  logic           ready_n, busy_n;

  assign oExpanderRst = rst | (state == KEY_RST);
  assign dbg_state    = state;

  always_comb begin
    state_n         = state;
    rekey_pending_n = rekey_pending | (iRekey & (state != IDLE));
    mode_n          = mode;
    eng_a_n         = oEngA;
    eng_b_n         = oEngB;
    ssel_n          = oSSel;
    cstart_n        = oCipherStart;
    dstart_n        = oDecipherStart;
    a_n             = oA;
    b_n             = oB;
    resp_valid_n    = oRespValid;
    resp_dec_n      = oRespDecrypt;
    case (state)
      KEY_RST: begin
        ssel_n   = SEL_EXP;
        cstart_n = 1'b0;
        dstart_n = 1'b0;
        state_n  = KEY_WAIT;
      end
      KEY_WAIT: if (iExpanderDone) state_n = IDLE;
      IDLE: begin
        // A rekey, new or deferred, wins over a request in the same cycle.
        if (iRekey || rekey_pending) begin
          state_n = KEY_RST;
        end else if (iReqValid) begin
          eng_a_n = iA;
          eng_b_n = iB;
          mode_n  = iReqDecrypt;
          ssel_n  = iReqDecrypt ? SEL_DEC : SEL_CIP;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        cstart_n = ~mode;
        dstart_n = mode;
        state_n  = RUN;
      end
      RUN: begin
        if ((!mode && iCipherDone) || (mode && iDecipherDone)) begin
          a_n          = mode ? iDecipherA : iCipherA;
          b_n          = mode ? iDecipherB : iCipherB;
          cstart_n     = 1'b0;
          dstart_n     = 1'b0;
          resp_valid_n = 1'b1;
          resp_dec_n   = mode;
          state_n      = RESP;
        end
      end
      RESP: begin
        if (iRespReady) begin
          resp_valid_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = KEY_RST;
    endcase
    if (state_n == KEY_RST) rekey_pending_n = 1'b0;
    ready_n = (state_n == IDLE) && !rekey_pending_n;
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= KEY_RST;
      rekey_pending  <= 1'b0;
      mode           <= 1'b0;
      oEngA          <= '0;
      oEngB          <= '0;
      oSSel          <= SEL_EXP;
      oCipherStart   <= 1'b0;
      oDecipherStart <= 1'b0;
      oA             <= '0;
      oB             <= '0;
      oRespValid     <= 1'b0;
      oRespDecrypt   <= 1'b0;
      oReqReady      <= 1'b0;
      oBusy          <= 1'b0;
    end else begin
      state          <= state_n;
      rekey_pending  <= rekey_pending_n;
      mode           <= mode_n;
      oEngA          <= eng_a_n;
      oEngB          <= eng_b_n;
      oSSel          <= ssel_n;
      oCipherStart   <= cstart_n;
      oDecipherStart <= dstart_n;
      oA             <= a_n;
      oB             <= b_n;
      oRespValid     <= resp_valid_n;
      oRespDecrypt   <= resp_dec_n;
      oReqReady      <= ready_n;
      oBusy          <= busy_n;
    end
  end

endmodule

// File: tb/tb_rc5_sequencer.sv
// Bench for rc5_sequencer: stub key expander and invertible stub engines,
// directed handshake/rekey/reset scenarios plus randomized traffic against a queue model.
module tb_rc5_sequencer;
  localparam int W = 16;

  logic clk, rst;
  logic iReqValid, iReqDecrypt, iRekey, iExpanderDone, iCipherDone, iDecipherDone, iRespReady;
  logic [W-1:0] iA, iB, iCipherA, iCipherB, iDecipherA, iDecipherB;
  logic oReqReady, oExpanderRst, oCipherStart, oDecipherStart, oRespValid, oRespDecrypt, oBusy;
  logic [W-1:0] oEngA, oEngB, oA, oB;
  logic [1:0] oSSel;
  logic [2:0] dbg_state;

  rc5_sequencer #(.W(W), .R(12)) dut (
    .clk(clk), .rst(rst), .iReqValid(iReqValid), .iReqDecrypt(iReqDecrypt),
    .iA(iA), .iB(iB), .oReqReady(oReqReady), .iRekey(iRekey),
    .oExpanderRst(oExpanderRst), .iExpanderDone(iExpanderDone),
    .oCipherStart(oCipherStart), .iCipherDone(iCipherDone),
    .iCipherA(iCipherA), .iCipherB(iCipherB),
    .oDecipherStart(oDecipherStart), .iDecipherDone(iDecipherDone),
    .iDecipherA(iDecipherA), .iDecipherB(iDecipherB),
    .oEngA(oEngA), .oEngB(oEngB), .oSSel(oSSel), .oA(oA), .oB(oB),
    .oRespValid(oRespValid), .oRespDecrypt(oRespDecrypt), .iRespReady(iRespReady),
    .oBusy(oBusy), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W:0] exp_q[$];

  // stub engines: cipher is an invertible mix, decipher its inverse
  function automatic logic [2*W-1:0] enc(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ra;
    ra = {a[W-4:0], a[W-1:W-3]};
    return {ra ^ 16'hA5C3, b + 16'h1357};
  endfunction

  function automatic logic [2*W-1:0] dec(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] xa;
    xa = a ^ 16'hA5C3;
    return {{xa[2:0], xa[W-1:3]}, b - 16'h1357};
  endfunction

  int lat_lo = 1, lat_hi = 6;
  logic fixed_out = 1'b0;
  logic spur = 1'b0;
  logic c_done = 1'b0, d_done = 1'b0;
  int c_cnt = 0, c_lat = 1, d_cnt = 0, d_lat = 1, x_cnt = 0, x_lat = 3;

  assign iCipherDone   = c_done;
  assign iDecipherDone = d_done | spur;

  always @(posedge clk) begin
    #2;
    if (oCipherStart) begin
      if (c_cnt >= c_lat) begin
        c_done = 1'b1;
        {iCipherA, iCipherB} = fixed_out ? {16'hAAAA, 16'h5555} : enc(oEngA, oEngB);
      end else c_cnt++;
    end else begin
      c_done = 1'b0; c_cnt = 0; c_lat = $urandom_range(lat_hi, lat_lo);
      iCipherA = 16'hBEEF; iCipherB = 16'hBEEF;
    end
    if (oDecipherStart) begin
      if (d_cnt >= d_lat) begin
        d_done = 1'b1;
        {iDecipherA, iDecipherB} = dec(oEngA, oEngB);
      end else d_cnt++;
    end else begin
      d_done = 1'b0; d_cnt = 0; d_lat = $urandom_range(lat_hi, lat_lo);
      iDecipherA = 16'hDEAD; iDecipherB = 16'hDEAD;
    end
    if (oExpanderRst) begin
      iExpanderDone = 1'b0; x_cnt = 0; x_lat = $urandom_range(6, 2);
    end else if (x_cnt >= x_lat) iExpanderDone = 1'b1;
    else x_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    while (!oReqReady && n < 200) begin @(negedge clk); n++; end
    if (!oReqReady) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_expander();
    int n = 0;
    while (!iExpanderDone && n < 100) begin
      check("ready_before_keys", oReqReady, 0);
      @(negedge clk); n++;
    end
    if (!iExpanderDone) check("expander_timeout", 0, 1);
    @(negedge clk);
    check("ready_after_keys", oReqReady, 1);
    check("ssel_after_keys", oSSel, 0);
    check("busy_after_keys", oBusy, 0);
  endtask

  task automatic issue(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W:0] exp);
    iReqValid = 1'b1; iReqDecrypt = d; iA = a; iB = b;
    exp_q.push_back(exp);
    @(negedge clk);
    iReqValid = 1'b0; iA = W'($urandom); iB = W'($urandom);
    check("accept_ssel", oSSel, d ? 2 : 1);
    check("accept_eng", {oEngA, oEngB}, {a, b});
    check("settle_starts", {oCipherStart, oDecipherStart}, 0);
    check("settle_busy", oBusy, 1);
    @(negedge clk);
    check("run_starts", {oCipherStart, oDecipherStart}, d ? 2'b01 : 2'b10);
  endtask

  task automatic collect(input int hold, input logic exp_ready);
    int n = 0;
    logic [2*W:0] exp;
    while (!oRespValid && n < 100) begin @(negedge clk); n++; end
    if (!oRespValid) begin check("resp_timeout", 0, 1); return; end
    if (exp_q.size() == 0) begin check("resp_unexpected", 1, 0); return; end
    exp = exp_q.pop_front();
    check("resp_data", {oRespDecrypt, oA, oB}, exp);
    check("resp_starts", {oCipherStart, oDecipherStart}, 0);
    repeat (hold) begin
      @(negedge clk);
      check("resp_hold", {oRespValid, oRespDecrypt, oA, oB}, {1'b1, exp});
      check("resp_hold_ready", oReqReady, 0);
    end
    iRespReady = 1'b1;
    @(negedge clk);
    iRespReady = 1'b0;
    check("resp_drop", oRespValid, 0);
    check("ready_after_resp", oReqReady, exp_ready);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] e;
    logic [W-1:0] p, q;
    rst = 1'b1; iReqValid = 1'b0; iReqDecrypt = 1'b0; iA = '0; iB = '0;
    iRekey = 1'b0; iRespReady = 1'b0;

    // reset and key schedule
    @(negedge clk);
    check("rst_exprst", oExpanderRst, 1);
    check("rst_outputs", {oReqReady, oCipherStart, oDecipherStart, oRespValid, oSSel, oBusy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("exprst_after_release", oExpanderRst, 1);
    @(negedge clk);
    check("exprst_one_cycle", oExpanderRst, 0);
    wait_expander();

    // directed encrypt with fixed engine result
    fixed_out = 1'b1;
    issue(1'b0, 16'h1234, 16'h5678, {1'b0, 16'hAAAA, 16'h5555});
    collect(0, 1'b1);
    fixed_out = 1'b0;

    // round trip
    e = enc(16'h1234, 16'h5678);
    issue(1'b0, 16'h1234, 16'h5678, {1'b0, e});
    collect(0, 1'b1);
    issue(1'b1, e[2*W-1:W], e[W-1:0], {1'b1, 16'h1234, 16'h5678});
    collect(1, 1'b1);

    // backpressure with a request waiting
    p = W'($urandom); q = W'($urandom);
    issue(1'b0, p, q, {1'b0, enc(p, q)});
    iReqValid = 1'b1; iReqDecrypt = 1'b1; iA = q; iB = p;
    collect(5, 1'b1);
    exp_q.push_back({1'b1, dec(q, p)});
    @(negedge clk);
    iReqValid = 1'b0;
    check("bp_accept_ssel", oSSel, 2);
    check("bp_accept_eng", {oEngA, oEngB}, {q, p});
    check("bp_accept_ready", oReqReady, 0);
    collect(0, 1'b1);

    // rekey and request in the same idle cycle
    iRekey = 1'b1; iReqValid = 1'b1; iReqDecrypt = 1'b0; iA = 16'h0F0F;
    @(negedge clk);
    iRekey = 1'b0; iReqValid = 1'b0;
    check("race_exprst", oExpanderRst, 1);
    check("race_no_accept", {oReqReady, oCipherStart, oDecipherStart}, 0);
    @(negedge clk);
    check("race_exprst_end", oExpanderRst, 0);
    wait_expander();

    // rekey during RUN plus spurious decipher done
    lat_lo = 4; lat_hi = 4;
    p = W'($urandom); q = W'($urandom);
    issue(1'b0, p, q, {1'b0, enc(p, q)});
    iRekey = 1'b1; spur = 1'b1;
    @(negedge clk);
    iRekey = 1'b0; spur = 1'b0;
    check("spur_ignored", oRespValid, 0);
    collect(0, 1'b0);
    check("pending_idle_exprst", oExpanderRst, 0);
    @(negedge clk);
    check("pending_exprst", oExpanderRst, 1);
    wait_expander();

    // reset mid-RUN
    lat_lo = 8; lat_hi = 8;
    issue(1'b1, 16'hC0DE, 16'hFACE, {1'b1, dec(16'hC0DE, 16'hFACE)});
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {oReqReady, oCipherStart, oDecipherStart, oRespValid, oRespDecrypt,
                             oSSel, oBusy, oEngA, oEngB, oA, oB}, 0);
    check("midrst_exprst", oExpanderRst, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_keyrst", oExpanderRst, 1);
    @(negedge clk);
    wait_expander();

    // randomized traffic
    lat_lo = 1; lat_hi = 6;
    for (int i = 0; i < 20; i++) begin
      logic d;
      d = 1'($urandom_range(1, 0));
      p = W'($urandom); q = W'($urandom);
      wait_ready();
      issue(d, p, q, {d, d ? dec(p, q) : enc(p, q)});
      collect($urandom_range(3, 0), 1'b1);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
